// File: rtl/slow_clk_monitor_pkg.sv
// Shared lift timing definitions: FSM encodings and divider-matched defaults for the slow clock monitor.
package slow_clk_monitor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ACQ   = 2'b01;
  localparam logic [1:0] ST_LOCK  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  localparam int unsigned HALF_PERIOD_DEF = 5;
  localparam int unsigned TOL_DEF         = 1;
  localparam int unsigned LOCK_N_DEF      = 4;
  localparam int unsigned CNT_W_DEF       = 4;

  // Inclusive window test used to judge a measured interval.
  function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                     input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/slow_edge_detect.sv
// Slow square-wave front end: optional 2-FF synchronizer (SLOW_CLK_SYNC_EN), sample/prev
// registers and combinational rise/fall/edge strobes aligned to the sampled level.
module slow_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic slow_in,
  output logic rise_c,
  output logic fall_c,
  output logic edge_c
);

  logic s_src;
  logic s;
  logic prev;

`ifdef SLOW_CLK_SYNC_EN
  logic sync1;
  logic sync2;

  // Metastability guard for slow_in arriving from another clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= slow_in;
      sync2 <= sync1;
    end
  end

  assign s_src = sync2;
`else
  assign s_src = slow_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s    <= 1'b0;
      prev <= 1'b0;
    end else begin
      s    <= s_src;
      prev <= s;
    end
  end

  assign rise_c = s & ~prev;
  assign fall_c = ~s & prev;
  assign edge_c = s ^ prev;

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow divided-clock monitor: edge ticks, half-period measurement and lock/fault tracking.
// Build option SLOW_CLK_SYNC_EN adds a 2-FF synchronizer ahead of the sampler.
module slow_clk_monitor
  import slow_clk_monitor_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int unsigned TOL         = TOL_DEF,
  parameter int unsigned LOCK_N      = LOCK_N_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_in,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic [CNT_W-1:0] half_cnt,
  output logic             locked,
  output logic             fault,
  output logic             fault_seen
);

  localparam int unsigned GOOD_W = $clog2(LOCK_N + 1);
  localparam int unsigned WIN_LO = HALF_PERIOD - TOL;
  localparam int unsigned WIN_HI = HALF_PERIOD + TOL;

  logic rise_c;
  logic fall_c;
  logic edge_c;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_nxt;
  logic [CNT_W-1:0]  half_nxt;
  logic              seen_nxt;

  logic [CNT_W:0]    interval_c;
  logic [CNT_W-1:0]  interval_sat_c;
  logic              cnt_max_c;
  logic              good_c;
  logic              timeout_c;

  slow_edge_detect u_edge (
    .clk     (clk),
    .reset   (reset),
    .slow_in (slow_in),
    .rise_c  (rise_c),
    .fall_c  (fall_c),
    .edge_c  (edge_c)
  );

  // Interval that would end on this cycle; widened so a saturated counter still reads as long.
  assign interval_c     = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign interval_sat_c = interval_c[CNT_W] ? {CNT_W{1'b1}} : interval_c[CNT_W-1:0];
  assign cnt_max_c      = (cnt == {CNT_W{1'b1}});
  assign good_c         = in_window(32'(interval_c), WIN_LO, WIN_HI);
  assign timeout_c      = !edge_c && (cnt == CNT_W'(WIN_HI));

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    half_nxt  = half_cnt;
    seen_nxt  = fault_seen;
    cnt_nxt   = edge_c ? '0 : (cnt_max_c ? cnt : cnt + CNT_W'(1));

    if (edge_c) begin
      if (state != ST_IDLE) half_nxt = interval_sat_c;
      case (state)
        ST_IDLE: begin
          state_nxt = ST_ACQ;
          good_nxt  = '0;
        end
        ST_ACQ: begin
          if (good_c) begin
            good_nxt = good_cnt + GOOD_W'(1);
            if (good_cnt == GOOD_W'(LOCK_N - 1)) state_nxt = ST_LOCK;
          end else begin
            good_nxt = '0;
          end
        end
        ST_LOCK: begin
          if (!good_c) begin
            state_nxt = ST_FAULT;
            seen_nxt  = 1'b1;
          end
        end
        default: begin
          // Re-acquire from fault; this edge only restarts measurement.
          state_nxt = ST_ACQ;
          good_nxt  = '0;
        end
      endcase
    end else if (timeout_c) begin
      case (state)
        ST_ACQ:  good_nxt = '0;
        ST_LOCK: begin
          state_nxt = ST_FAULT;
          seen_nxt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      good_cnt   <= '0;
      half_cnt   <= '0;
      fault_seen <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      tick_rise  <= 1'b0;
      tick_fall  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      good_cnt   <= good_nxt;
      half_cnt   <= half_nxt;
      fault_seen <= seen_nxt;
      locked     <= (state_nxt == ST_LOCK);
      fault      <= (state_nxt == ST_FAULT);
      tick_rise  <= rise_c;
      tick_fall  <= fall_c;
    end
  end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Self-checking bench for slow_clk_monitor: directed scenarios plus random toggling, compared
// cycle-by-cycle against an event-level model of edge timing and lock/fault rules.
module tb_slow_clk_monitor;

  localparam int HP     = 5;
  localparam int TOL    = 1;
  localparam int LOCKN  = 4;
  localparam int SAT    = 15;
  localparam int OFS    = 8;
`ifdef SLOW_CLK_SYNC_EN
  localparam int LAT    = 4;
`else
  localparam int LAT    = 2;
`endif

  typedef enum int {M_IDLE, M_ACQ, M_LOCK, M_FAULT} mstate_t;

  logic       clk;
  logic       reset;
  logic       slow_in;
  logic       tick_rise;
  logic       tick_fall;
  logic [3:0] half_cnt;
  logic       locked;
  logic       fault;
  logic       fault_seen;

  slow_clk_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .slow_in    (slow_in),
    .tick_rise  (tick_rise),
    .tick_fall  (tick_fall),
    .half_cnt   (half_cnt),
    .locked     (locked),
    .fault      (fault),
    .fault_seen (fault_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      n_chk  = 0;
  int      n_pass = 0;
  int      cyc    = 0;
  logic    hist [0:8191];
  logic    lvl_cur;

  mstate_t m_st;
  int      m_good;
  int      m_last;
  int      m_half;
  logic    m_seen;
  logic    m_rise;
  logic    m_fall;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
  endtask

  // Model: edges seen LAT cycles after the sampling edge; intervals are cycle distances.
  task automatic model_step(input logic rst);
    logic cur, old;
    int   iv;
    logic ok;
    if (rst) begin
      for (int j = cyc - 5; j <= cyc; j++) hist[j + OFS] = 1'b0;
      m_st = M_IDLE; m_good = 0; m_last = cyc; m_half = 0;
      m_seen = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      return;
    end
    cur    = hist[cyc - LAT + 1 + OFS];
    old    = hist[cyc - LAT + OFS];
    m_rise = cur & ~old;
    m_fall = ~cur & old;
    iv     = cyc - m_last;
    if (cur != old) begin
      if (m_st == M_IDLE) begin
        m_st = M_ACQ; m_good = 0;
      end else begin
        m_half = (iv > SAT) ? SAT : iv;
        ok = (iv >= HP - TOL) && (iv <= HP + TOL);
        case (m_st)
          M_ACQ: begin
            if (ok) begin
              m_good++;
              if (m_good == LOCKN) m_st = M_LOCK;
            end else m_good = 0;
          end
          M_LOCK: if (!ok) begin m_st = M_FAULT; m_seen = 1'b1; end
          default: begin m_st = M_ACQ; m_good = 0; end
        endcase
      end
      m_last = cyc;
    end else if (iv == HP + TOL + 1) begin
      if (m_st == M_ACQ) m_good = 0;
      else if (m_st == M_LOCK) begin m_st = M_FAULT; m_seen = 1'b1; end
    end
  endtask

  task automatic step(input logic lvl, input logic rst);
    slow_in = lvl;
    reset   = rst;
    @(posedge clk);
    #1;
    cyc++;
    hist[cyc + OFS] = lvl;
    model_step(rst);
    check("tick_rise",  int'(tick_rise),  int'(m_rise));
    check("tick_fall",  int'(tick_fall),  int'(m_fall));
    check("half_cnt",   int'(half_cnt),   m_half);
    check("locked",     int'(locked),     int'(m_st == M_LOCK));
    check("fault",      int'(fault),      int'(m_st == M_FAULT));
    check("fault_seen", int'(fault_seen), int'(m_seen));
  endtask

  task automatic hold(input int n);
    repeat (n) step(lvl_cur, 1'b0);
  endtask

  task automatic toggles(input int n_edges, input int half);
    repeat (n_edges) begin
      lvl_cur = ~lvl_cur;
      hold(half);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) hist[i] = 1'b0;
    m_st = M_IDLE; m_good = 0; m_last = 0; m_half = 0;
    m_seen = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    lvl_cur = 1'b0;
    slow_in = 1'b0;
    reset   = 1'b1;

    // Reset, then nominal divide-by-10 toggling until lock
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst_half", int'(half_cnt), 0);
    toggles(8, 5);
    check("p1_locked", int'(locked), 1);

    // In-tolerance jitter keeps lock; a 7-cycle interval faults
    toggles(1, 4);
    toggles(1, 6);
    toggles(1, 7);
    check("p2_still_locked", int'(locked), 1);
    toggles(1, 5);
    check("p2_fault", int'(fault), 1);
    check("p2_half7", int'(half_cnt), 7);

    // Relock, then stall the input: timeout fault and counter saturation
    toggles(7, 5);
    check("p3_relocked", int'(locked), 1);
    hold(25);
    check("p3_timeout_fault", int'(fault), 1);

    // Resume: re-acquire and relock, sticky flag survives
    toggles(7, 5);
    check("p4_locked", int'(locked), 1);
    check("p4_seen", int'(fault_seen), 1);

    // Single-cycle reset with a toggle during it
    lvl_cur = ~lvl_cur;
    step(lvl_cur, 1'b1);
    check("p5_rst_locked", int'(locked), 0);
    check("p5_rst_seen", int'(fault_seen), 0);
    toggles(8, 5);
    check("p5_relocked", int'(locked), 1);

    // Random intervals, stalls and short resets
    repeat (180) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0) begin
        repeat ($urandom_range(1, 3)) begin
          lvl_cur = 1'($urandom_range(0, 1));
          step(lvl_cur, 1'b1);
        end
      end else if (r == 1) begin
        hold(int'($urandom_range(5, 20)));
      end else if (r < 8) begin
        toggles(1, int'($urandom_range(4, 6)));
      end else begin
        toggles(1, int'($urandom_range(2, 9)));
      end
    end
    hold(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

endmodule
